// File: rtl/instr_encoder_pkg.sv
// Shared opcode/funct constants, descriptor kind codes and field-packing helpers
// for the instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_ADD  = 3'd1,
    KIND_AND  = 3'd2,
    KIND_J    = 3'd3,
    KIND_BNE  = 3'd4,
    KIND_SW   = 3'd5,
    KIND_LW   = 3'd6,
    KIND_ADDI = 3'd7
  } kind_e;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_ADDI   = 6'h08;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_AND = 6'h24;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm16);
    return {op, rs, rt, imm16};
  endfunction

  function automatic logic [5:0] i_opcode(input kind_e kind);
    logic [5:0] op;
    case (kind)
      KIND_BNE: op = OP_BNE;
      KIND_SW:  op = OP_SW;
      KIND_LW:  op = OP_LW;
      default:  op = OP_ADDI;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational descriptor packer: kind + register/immediate fields -> 32-bit word,
// plus a reject flag for I-type descriptors whose immediate does not fit in 16 bits.
module instr_encoder_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        reject_o
);

  kind_e kind;
  logic  imm_hi_nz;

  assign kind      = kind_e'(kind_i);
  assign imm_hi_nz = |imm_i[25:16];

  always_comb begin
    word_o   = '0;
    reject_o = 1'b0;
    case (kind)
      KIND_NOP: word_o = '0;
      KIND_ADD: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_ADD);
      KIND_AND: word_o = enc_r(rs_i, rt_i, rd_i, FUNCT_AND);
      KIND_J:   word_o = {OP_J, imm_i};
      // I-type: an immediate wider than 16 bits cannot be represented, so drop it
      KIND_BNE, KIND_SW, KIND_LW, KIND_ADDI: begin
        reject_o = imm_hi_nz;
        if (!imm_hi_nz) begin
          word_o = enc_i(i_opcode(kind), rs_i, rt_i, imm_i[15:0]);
        end
      end
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Descriptor-to-instruction encoder: valid/ready in, imem write stream out, with one
// output register, one skid register, a sequential address counter and status counters.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [25:0]           in_imm,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic [7:0]            err_count,
  output logic                  error,
  output logic                  wrapped
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  function automatic logic [ADDR_WIDTH:0] sat_inc_cnt(input logic [ADDR_WIDTH:0] v);
    return (v == '1) ? v : v + (ADDR_WIDTH+1)'(1);
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0]           pack_word;
  logic                  pack_reject;

  logic                  out_vld_q,  out_vld_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [31:0]           out_data_q, out_data_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic [31:0]           skid_data_q, skid_data_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH:0]   count_q,    count_d;
  logic [7:0]            err_cnt_q,  err_cnt_d;
  logic                  error_q,    error_d;
  logic                  wrapped_q,  wrapped_d;

  logic accept, emit, wr_hs;

  instr_encoder_field_pack u_pack (
    .kind_i   (in_kind),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .imm_i    (in_imm),
    .word_o   (pack_word),
    .reject_o (pack_reject)
  );

  // Ready depends only on skid occupancy, never on wr_ready.
  assign in_ready = ~skid_vld_q & ~restart & ~reset;
  assign accept   = in_valid & in_ready;
  assign emit     = accept & ~pack_reject;
  assign wr_hs    = out_vld_q & wr_ready;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    skid_vld_d  = skid_vld_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_cnt_d   = err_cnt_q;
    error_d     = error_q;
    wrapped_d   = wrapped_q;

    if (!out_vld_q || wr_ready) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_addr_d = skid_addr_q;
        out_data_d = skid_data_q;
        skid_vld_d = 1'b0;
      end else if (emit) begin
        out_vld_d  = 1'b1;
        out_addr_d = addr_q;
        out_data_d = pack_word;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (emit) begin
      skid_vld_d  = 1'b1;
      skid_addr_d = addr_q;
      skid_data_d = pack_word;
    end

    // Address is bound at encode time so a stalled word keeps its slot.
    if (emit) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      if (addr_q == '1) begin
        wrapped_d = 1'b1;
      end
    end

    if (wr_hs) begin
      count_d = sat_inc_cnt(count_q);
    end

    if (accept && pack_reject) begin
      error_d   = 1'b1;
      err_cnt_d = sat_inc_err(err_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      out_vld_q  <= 1'b0;
      out_addr_q <= BASE;
      out_data_q <= '0;
      skid_vld_q <= 1'b0;
      addr_q     <= BASE;
      count_q    <= '0;
      err_cnt_q  <= '0;
      error_q    <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      skid_vld_q <= skid_vld_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
      error_q    <= error_d;
      wrapped_q  <= wrapped_d;
    end
  end

  // Skid payload is only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    skid_addr_q <= skid_addr_d;
    skid_data_q <= skid_data_d;
  end

  assign wr_valid  = out_vld_q;
  assign wr_addr   = out_addr_q;
  assign wr_data   = out_data_q;
  assign count     = count_q;
  assign err_count = err_cnt_q;
  assign error     = error_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed descriptors push expected words, and
// independent monitors pop and compare on every write handshake.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, restart, in_valid, in_ready, wr_valid, wr_ready, error, wrapped;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [25:0] in_imm;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;
  logic [7:0]  err_count;

  logic        s_restart, s_in_valid, s_in_ready, s_wr_valid, s_wr_ready, s_error, s_wrapped;
  logic [2:0]  s_in_kind;
  logic [4:0]  s_in_rs, s_in_rt, s_in_rd;
  logic [25:0] s_in_imm;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_count;
  logic [7:0]  s_err_count;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  logic [1:0]  sexp_q[$];
  logic [39:0] mon_e;
  logic [1:0]  smon_e;

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .err_count(err_count), .error(error), .wrapped(wrapped)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_small (
    .clk(clk), .reset(reset), .restart(s_restart),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_kind(s_in_kind),
    .in_rs(s_in_rs), .in_rt(s_in_rt), .in_rd(s_in_rd), .in_imm(s_in_imm),
    .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .count(s_count), .err_count(s_err_count), .error(s_error), .wrapped(s_wrapped)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_word actual=%0h@%0h required=none", wr_data, wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_word", {24'h0, wr_addr, wr_data}, {24'h0, mon_e});
      end
    end
  end

  always @(negedge clk) begin
    if (s_wr_valid === 1'b1 && s_wr_ready === 1'b1) begin
      if (sexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_wr_word actual=%0h@%0h required=none", s_wr_data, s_wr_addr);
      end else begin
        smon_e = sexp_q.pop_front();
        chk("s_wr_word", {30'h0, s_wr_addr, s_wr_data}, {30'h0, smon_e, 32'h0});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input bit emit,
                      input logic [7:0] ea, input logic [31:0] ed, output int waited);
    bit done;
    done   = 1'b0;
    waited = 0;
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    while (!done && waited < 20) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        if (emit) exp_q.push_back({ea, ed});
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept kind=%0d", k);
    end
  endtask

  task automatic do_restart();
    exp_q.delete();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] sa [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    int w;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    s_restart = 1'b0; s_in_valid = 1'b0; s_wr_ready = 1'b0;
    s_in_kind = '0; s_in_rs = '0; s_in_rt = '0; s_in_rd = '0; s_in_imm = '0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_during_reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_error", error, 0);
    chk("rst_wrapped", wrapped, 0);
    @(posedge clk); #1;

    // Single ADD
    wr_ready = 1'b1;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd0, 32'h00221820, w);
    idle(2);
    chk("add_count", count, 1);

    // Back-to-back ADDI, LW, J
    do_restart();
    send(3'd7, 5'd0, 5'd5, 5'd0, 26'h10, 1, 8'd0, 32'h20050010, w);
    chk("b2b_wait_addi", w, 0);
    send(3'd6, 5'd4, 5'd8, 5'd0, 26'h4, 1, 8'd1, 32'h8C880004, w);
    chk("b2b_wait_lw", w, 0);
    send(3'd3, 5'd0, 5'd0, 5'd0, 26'h10, 1, 8'd2, 32'h08000010, w);
    chk("b2b_wait_j", w, 0);
    idle(2);
    chk("b2b_count", count, 3);

    // Rejections and remaining encodings
    do_restart();
    send(3'd4, 5'd1, 5'd2, 5'd0, 26'h10000, 0, 8'd0, 32'h0, w);
    @(negedge clk);
    chk("rej_wr_valid", wr_valid, 0);
    chk("rej_error", error, 1);
    chk("rej_err_count", err_count, 1);
    @(posedge clk); #1;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd0, 32'h00221820, w);
    send(3'd7, 5'd1, 5'd1, 5'd0, 26'h3FF0000, 0, 8'd0, 32'h0, w);
    send(3'd2, 5'd7, 5'd8, 5'd9, 26'h0, 1, 8'd1, 32'h00E84824, w);
    send(3'd4, 5'd3, 5'd4, 5'd0, 26'hFFFC, 1, 8'd2, 32'h1464FFFC, w);
    send(3'd5, 5'd29, 5'd31, 5'd0, 26'h8, 1, 8'd3, 32'hAFBF0008, w);
    send(3'd0, 5'd5, 5'd6, 5'd7, 26'h123, 1, 8'd4, 32'h00000000, w);
    send(3'd3, 5'd9, 5'd9, 5'd9, 26'h3FFFFFF, 1, 8'd5, 32'h0BFFFFFF, w);
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF, 1, 8'd6, 32'h00221820, w);
    send(3'd6, 5'd0, 5'd1, 5'd0, 26'hFFFF, 1, 8'd7, 32'h8C01FFFF, w);
    idle(2);
    chk("mix_err_count", err_count, 2);
    chk("mix_count", count, 8);

    // Backpressure: two accepted, then stalled
    do_restart();
    wr_ready = 1'b0;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd0, 32'h00221820, w);
    send(3'd2, 5'd7, 5'd8, 5'd9, 26'h0, 1, 8'd1, 32'h00E84824, w);
    in_valid = 1'b1; in_kind = 3'd3; in_imm = 26'h10;
    @(negedge clk);
    chk("bp_in_ready_0", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_1", in_ready, 0);
    chk("bp_hold_valid", wr_valid, 1);
    chk("bp_hold_data", wr_data, 32'h00221820);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(3'd3, 5'd0, 5'd0, 5'd0, 26'h10, 1, 8'd2, 32'h08000010, w);
    idle(3);
    chk("bp_count", count, 3);

    // Restart with two words pending
    send(3'd4, 5'd1, 5'd2, 5'd0, 26'h10000, 0, 8'd0, 32'h0, w);
    wr_ready = 1'b0;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd3, 32'h00221820, w);
    send(3'd2, 5'd7, 5'd8, 5'd9, 26'h0, 1, 8'd4, 32'h00E84824, w);
    chk("rs_error_before", error, 1);
    restart = 1'b1; in_valid = 1'b1; in_kind = 3'd1;
    @(negedge clk);
    chk("rs_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    restart = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rs_wr_valid", wr_valid, 0);
    chk("rs_wr_addr", wr_addr, 0);
    chk("rs_count", count, 0);
    chk("rs_error", error, 0);
    chk("rs_err_count", err_count, 0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd0, 32'h00221820, w);
    idle(2);
    chk("rs_after_count", count, 1);

    // Reset with two words pending
    send(3'd6, 5'd1, 5'd1, 5'd0, 26'h20000, 0, 8'd0, 32'h0, w);
    wr_ready = 1'b0;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd1, 32'h00221820, w);
    send(3'd2, 5'd7, 5'd8, 5'd9, 26'h0, 1, 8'd2, 32'h00E84824, w);
    reset = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst2_wr_valid", wr_valid, 0);
    chk("rst2_wr_addr", wr_addr, 0);
    chk("rst2_count", count, 0);
    chk("rst2_error", error, 0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    send(3'd1, 5'd1, 5'd2, 5'd3, 26'h0, 1, 8'd0, 32'h00221820, w);
    idle(2);
    chk("rst2_after_count", count, 1);

    // ADDR_WIDTH=2: address wrap and count saturation
    s_wr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_in_valid = 1'b1;
      @(negedge clk);
      chk("s_in_ready", s_in_ready, 1);
      sexp_q.push_back(sa[i]);
      @(posedge clk); #1;
      if (i == 2) chk("s_wrapped_early", s_wrapped, 0);
      if (i == 4) begin
        s_in_valid = 1'b0;
        idle(2);
        chk("s_count5", s_count, 5);
        chk("s_wrapped", s_wrapped, 1);
      end
    end
    s_in_valid = 1'b0;
    idle(2);
    chk("s_count_sat", s_count, 7);

    idle(4);
    chk("main_queue_left", exp_q.size(), 0);
    chk("small_queue_left", sexp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
